// File: rtl/tlul_reg_host.sv
// TL-UL host adapter: register-style req/gnt port in, TL-UL A/D channels out, one-cycle response strobe back.
// Optional in-order response checking (source and opcode) is enabled with `define TLUL_HOST_RSP_CHECK_EN.
module tlul_reg_host #(
   parameter int MaxOutstanding = 2,
   parameter int RegAw          = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_i,
   output logic             gnt_o,
   input  logic [RegAw-1:0] addr_i,
   input  logic             we_i,
   input  logic [31:0]      wdata_i,
   input  logic [3:0]       be_i,
   output logic             valid_o,
   output logic [31:0]      rdata_o,
   output logic             err_o,
   output logic             busy_o,
   output logic             unexp_rsp_o,
   output logic [108:0]     tl_o,
   input  logic [65:0]      tl_i
);
   localparam int CntW = $clog2(MaxOutstanding + 1);
   localparam int SrcW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   localparam logic [2:0] OpGet         = 3'h4;
   localparam logic [2:0] OpPutFull     = 3'h0;
   localparam logic [2:0] OpPutPartial  = 3'h1;
   localparam logic [2:0] OpAccessAck   = 3'h0;
   localparam logic [2:0] OpAccessAckDt = 3'h1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic [22:0] a_user;
      logic        d_ready;
   } h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic [13:0] d_user;
      logic        d_error;
      logic        a_ready;
   } d2h_t;

   function automatic logic [SrcW-1:0] src_inc(input logic [SrcW-1:0] s);
      return (s == SrcW'(MaxOutstanding - 1)) ? '0 : s + SrcW'(1);
   endfunction

   h2d_t h2d;
   d2h_t d2h;
   logic [31:0] addr_full;

   logic [SrcW-1:0] src_q, src_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            unexp_q, unexp_d;

   logic full, a_valid, d_beat, exp_beat, chk_fail;

   assign d2h       = d2h_t'(tl_i);
   assign tl_o      = h2d;
   assign addr_full = 32'(addr_i);

   assign full     = (cnt_q == CntW'(MaxOutstanding));
   assign a_valid  = req_i & ~full;
   assign gnt_o    = a_valid & d2h.a_ready;
   // d_ready is tied high, so every d_valid is an accepted beat
   assign d_beat   = d2h.d_valid;
   assign exp_beat = d_beat & (cnt_q != '0);

   always_comb begin
      h2d           = '0;
      h2d.a_valid   = a_valid;
      h2d.a_size    = 2'd2;
      h2d.a_source  = 8'(src_q);
      h2d.a_address = {addr_full[31:2], 2'b00};
      h2d.a_user    = {5'b0, 4'h9, 7'b0, 7'b0};
      h2d.d_ready   = 1'b1;
      if (!we_i) begin
         h2d.a_opcode = OpGet;
         h2d.a_mask   = 4'hF;
      end else if (be_i == 4'hF) begin
         h2d.a_opcode = OpPutFull;
         h2d.a_mask   = 4'hF;
         h2d.a_data   = wdata_i;
      end else begin
         h2d.a_opcode = OpPutPartial;
         h2d.a_mask   = be_i;
         h2d.a_data   = wdata_i;
      end
   end

`ifdef TLUL_HOST_RSP_CHECK_EN
   // Sources are issued and retired in the same wrapping order, so the two source
   // counters double as write/read pointers of the is_read FIFO.
   logic [SrcW-1:0]           rsp_src_q, rsp_src_d;
   logic [MaxOutstanding-1:0] rd_fifo_q, rd_fifo_d;

   always_comb begin
      rd_fifo_d = rd_fifo_q;
      rsp_src_d = rsp_src_q;
      if (gnt_o) rd_fifo_d[src_q] = ~we_i;
      if (exp_beat) rsp_src_d = src_inc(rsp_src_q);
      chk_fail = exp_beat &&
                 ((d2h.d_source != 8'(rsp_src_q)) ||
                  (d2h.d_opcode != (rd_fifo_q[rsp_src_q] ? OpAccessAckDt : OpAccessAck)));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_src_q <= '0;
         rd_fifo_q <= '0;
      end else begin
         rsp_src_q <= rsp_src_d;
         rd_fifo_q <= rd_fifo_d;
      end
   end
`else
   assign chk_fail = 1'b0;
`endif

   always_comb begin
      src_d   = src_q;
      cnt_d   = cnt_q;
      unexp_d = unexp_q;
      valid_d = exp_beat;
      err_d   = err_q;
      rdata_d = rdata_q;
      if (gnt_o) src_d = src_inc(src_q);
      if (gnt_o && !exp_beat) cnt_d = cnt_q + CntW'(1);
      else if (!gnt_o && exp_beat) cnt_d = cnt_q - CntW'(1);
      if (d_beat && (cnt_q == '0)) unexp_d = 1'b1;
      if (exp_beat) begin
         err_d   = d2h.d_error | chk_fail;
         rdata_d = ((d2h.d_opcode == OpAccessAckDt) && !err_d) ? d2h.d_data : '1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         unexp_q <= 1'b0;
      end else begin
         src_q   <= src_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         unexp_q <= unexp_d;
      end
   end

   assign valid_o     = valid_q;
   assign err_o       = err_q;
   assign rdata_o     = rdata_q;
   assign unexp_rsp_o = unexp_q;
   assign busy_o      = (cnt_q != '0);

   logic unused_tl;
   assign unused_tl = ^{d2h.d_param, d2h.d_size, d2h.d_source, d2h.d_sink, d2h.d_user,
                        addr_full[1:0]};
endmodule
